// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multicycle load/store unit for a non-pipelined RV32I core. One load or store
// request becomes a single word-aligned memory transaction over a req/ack
// handshake. The unit generates byte enables and write-data lanes, and it
// returns sign- or zero-extended load data to the writeback path.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   If defined, an ack watchdog aborts a REQ that waits TIMEOUT cycles and
//   reports it with fault. If not defined, REQ waits for mem_ack indefinitely.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle request, sampled only in IDLE
//   ir                   instruction (opcode ir[6:0], funct3 ir[14:12])
//   addr, store_data     byte address and rs2 value, sampled with start
//   busy                 high from the cycle after an accepted start to done
//   done, fault          one-cycle completion pulse / error flag (with done)
//   load_data            extended load result, held until the next good load
//   mem_req, mem_we      memory request strobe and write select
//   mem_addr             word-aligned address
//   mem_be, mem_wdata    byte enables and lane-replicated store data
//   mem_rdata, mem_ack   memory response
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [1:0]  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  offset_q, offset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] load_data_q, load_data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Only the opcode and funct3 fields of the instruction matter here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[31:15], ir[11:7]};

    logic        req_is_load, req_is_store, req_legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    assign req_is_load  = (ir[6:0] == OP_LOAD);
    assign req_is_store = (ir[6:0] == OP_STORE);

    // Legality check: the funct3 encoding must be valid, and the address must
    // be aligned to the natural access size.
    always_comb begin
        req_legal = 1'b0;
        if (req_is_load) begin
            case (ir[14:12])
                3'b000, 3'b100: req_legal = 1'b1;
                3'b001, 3'b101: req_legal = ~addr[0];
                3'b010:         req_legal = (addr[1:0] == 2'b00);
                default:        req_legal = 1'b0;
            endcase
        end else if (req_is_store) begin
            case (ir[14:12])
                3'b000:  req_legal = 1'b1;
                3'b001:  req_legal = ~addr[0];
                3'b010:  req_legal = (addr[1:0] == 2'b00);
                default: req_legal = 1'b0;
            endcase
        end
    end

    // Store lanes: replicate the data so that every byte enable selects the
    // correct bytes without a barrel shift.
    always_comb begin
        case (ir[13:12])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << addr[1:0];
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Load extraction: move the addressed byte or half to bit 0, then extend it.
    assign rdata_shifted = mem_rdata >> {offset_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_ext = {24'h0, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {16'h0, rdata_shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        offset_d    = offset_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        load_data_d = load_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && (req_is_load || req_is_store)) begin
                    funct3_d   = ir[14:12];
                    is_store_d = req_is_store;
                    offset_d   = addr[1:0];
                    busy_d     = 1'b1;
                    if (req_legal) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = req_is_store;
                        mem_addr_d = {addr[31:2], 2'b00};
                        mem_be_d   = req_is_store ? st_be : 4'b1111;
                        if (req_is_store) begin
                            mem_wdata_d = st_wdata;
                        end
`ifdef LSU_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        // An illegal access reports a fault immediately and
                        // never reaches the memory port.
                        state_d = RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    if (!is_store_q) begin
                        load_data_d = load_ext;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    fault_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b000;
            is_store_q  <= 1'b0;
            offset_q    <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            load_data_q <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            offset_q    <= offset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign load_data = load_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed, self-checking bench for load_store_unit. Each scenario is a task
// that drives stimulus on the falling edge and compares DUT outputs against
// hand-computed constants. If LSU_TIMEOUT_EN is defined, the bench expects the
// watchdog behaviour; otherwise it expects an unbounded wait.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, fault;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ir         (ir),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // Present one start pulse. Returns at the falling edge of the cycle after
    // acceptance (cycle N+1).
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        ir         = {17'h0, f3, 5'h0, op};
        addr       = a;
        store_data = sd;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, fault, mem_req, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {busy, done, fault, mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_be, mem_wdata, load_data} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h/%h exp zeros", mem_addr, mem_be, mem_wdata, load_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got %b exp 0", busy);
        end
        $display("tx reset: outputs cleared");
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data);
        issue(OP_LOAD, f3, 32'h0000_0103, 32'h0);
        checks++;
        if ({mem_req, busy, mem_we, done} !== 4'b1100) begin
            errors++;
            $display("FAIL lb_req_flags got %b exp 1100", {mem_req, busy, mem_we, done});
        end
        checks++;
        if (mem_addr !== 32'h0000_0100 || mem_be !== 4'b1111) begin
            errors++;
            $display("FAIL lb_addr_be got %h/%b exp 00000100/1111", mem_addr, mem_be);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF_1234;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if ({done, fault, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL lb_done got %b exp 100", {done, fault, mem_req});
        end
        checks++;
        if (load_data !== exp_data) begin
            errors++;
            $display("FAIL lb_data f3=%b got %h exp %h", f3, load_data, exp_data);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL lb_return_idle got %b exp 00", {done, busy});
        end
        $display("tx load f3=%b addr=00000103 data=%h", f3, load_data);
    endtask

    task automatic test_store_half;
        issue(OP_STORE, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ack = 1'b1;
            checks++;
            if ({mem_req, mem_we, done} !== 3'b110 || mem_be !== 4'b1100 ||
                mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h0000_0020) begin
                errors++;
                $display("FAIL sh_req_cycle%0d got req/we/done=%b be=%b wdata=%h addr=%h exp 110 1100 beefbeef 00000020",
                         i, {mem_req, mem_we, done}, mem_be, mem_wdata, mem_addr);
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++;
        if ({done, fault, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL sh_done got %b exp 100", {done, fault, mem_req});
        end
        checks++;
        if (load_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL sh_load_data_kept got %h exp 00000080", load_data);
        end
        @(negedge clk);
        $display("tx store SH addr=00000022 be=1100 wdata=beefbeef");
    endtask

    task automatic test_fault(input logic [2:0] f3, input logic [31:0] a);
        issue(OP_LOAD, f3, a, 32'h0);
        checks++;
        if ({done, fault, mem_req, busy} !== 4'b1101) begin
            errors++;
            $display("FAIL fault_f3_%b got done/fault/req/busy=%b exp 1101", f3, {done, fault, mem_req, busy});
        end
        checks++;
        if (load_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL fault_load_data got %h exp 00000080", load_data);
        end
        @(negedge clk);
        checks++;
        if ({done, fault, mem_req, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL fault_after got %b exp 0000", {done, fault, mem_req, busy});
        end
        $display("tx fault load f3=%b addr=%h", f3, a);
    endtask

    task automatic test_ignored_opcode;
        issue(OP_RTYPE, 3'b000, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy, done, mem_req} !== 3'b000) begin
                errors++;
                $display("FAIL rtype_ignored cycle%0d got %b exp 000", i, {busy, done, mem_req});
            end
            @(negedge clk);
        end
        $display("tx rtype start ignored");
    endtask

    task automatic test_start_while_busy;
        int n_done;
        issue(OP_LOAD, 3'b010, 32'h0000_0080, 32'h0);
        ir         = {17'h0, 3'b010, 5'h0, OP_STORE};
        addr       = 32'h0000_0200;
        store_data = 32'h5555_AAAA;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0080) begin
            errors++;
            $display("FAIL busy_start_ignored got req=%b we=%b addr=%h exp 1 0 00000080", mem_req, mem_we, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        n_done  = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL busy_done_count got %0d exp 1", n_done);
        end
        checks++;
        if (load_data !== 32'h1234_5678 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL busy_lw_data got %h req=%b exp 12345678 0", load_data, mem_req);
        end
        $display("tx LW addr=00000080 with start during REQ, data=%h", load_data);
    endtask

    task automatic test_timeout;
        int n_req;
        issue(OP_LOAD, 3'b010, 32'h0000_0040, 32'h0);
        n_req = 0;
        while (mem_req === 1'b1 && n_req < 100) begin
            n_req++;
            @(negedge clk);
        end
`ifdef LSU_TIMEOUT_EN
        checks++;
        if (n_req != 16) begin
            errors++;
            $display("FAIL timeout_req_cycles got %0d exp 16", n_req);
        end
        checks++;
        if ({done, fault, mem_req} !== 3'b110) begin
            errors++;
            $display("FAIL timeout_done_fault got %b exp 110", {done, fault, mem_req});
        end
        checks++;
        if (load_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL timeout_load_data got %h exp 12345678", load_data);
        end
        @(negedge clk);
        $display("tx LW timeout after %0d cycles", n_req);
`else
        checks++;
        if (n_req != 100 || mem_req !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_wait got %0d cycles req=%b done=%b exp 100 1 0", n_req, mem_req, done);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("tx LW pending %0d cycles, cleared by reset", n_req);
`endif
    endtask

    task automatic test_reset_mid_req;
        int n_done;
        issue(OP_STORE, 3'b010, 32'h0000_0030, 32'hCAFE_F00D);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstreq_pre got %b exp 1", mem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstreq_async got req=%b busy=%b exp 0 0", mem_req, busy);
        end
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL rstreq_no_done got %0d exp 0", n_done);
        end
        issue(OP_STORE, 3'b010, 32'h0000_0010, 32'h1122_3344);
        checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_be !== 4'b1111 ||
            mem_wdata !== 32'h1122_3344 || mem_addr !== 32'h0000_0010) begin
            errors++;
            $display("FAIL sw_after_rst got req/we=%b be=%b wdata=%h addr=%h exp 11 1111 11223344 00000010",
                     {mem_req, mem_we}, mem_be, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if ({done, fault, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL sw_after_rst_done got %b exp 100", {done, fault, mem_req});
        end
        @(negedge clk);
        $display("tx reset during REQ abandoned; SW addr=00000010 completed");
    endtask

    initial begin
        test_reset;
        test_load_byte(3'b000, 32'hFFFF_FF80);
        test_load_byte(3'b100, 32'h0000_0080);
        test_store_half;
        test_fault(3'b010, 32'h0000_0041);
        test_fault(3'b011, 32'h0000_0040);
        test_ignored_opcode;
        test_start_while_busy;
        test_timeout;
        test_reset_mid_req;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit for the non-pipelined RV32I core. It sits between the ALU address output (`A+IMM` for L/S opcodes) and the data memory port. It turns one load or store request into a single word-aligned memory transaction using a req/ack handshake, generates byte enables and write-data lanes, and returns sign- or zero-extended load data to the register writeback path.

## Interface
- `TIMEOUT`, 16: ack watchdog limit in cycles (used only when `LSU_TIMEOUT_EN` is defined).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request from control in the MEM step; sampled only in IDLE.
- `ir` in 32: instruction; `ir[6:0]` is the opcode (`0000011` load, `0100011` store), `ir[14:12]` is funct3.
- `addr` in 32: byte address (ALU result); sampled with `start`.
- `store_data` in 32: rs2 value; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`/`fault`, inclusive.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: one-cycle pulse, coincident with `done`; signals a misaligned access, illegal funct3, or timeout.
- `load_data` out 32: extended load result; holds its value until the next successful load.
- `mem_req`, `mem_we` out 1: request strobe and write select.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32, `mem_ack` in 1: response from memory.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE + `start` + L/S opcode: the block latches `ir[14:12]`, opcode, `addr` and `store_data`, then checks legality.
  - Legal access: go to REQ.
  - Illegal access: go to RESP with fault, and issue no memory access.
- IDLE + `start` with any other opcode: ignored. No `busy`, no `done`.
- Legal loads: LB/LBU at any address; LH/LHU with `addr[0]=0`; LW with `addr[1:0]=0`.
- Legal stores: SB at any address; SH with `addr[0]=0`; SW with `addr[1:0]=0`.
- Any other funct3 is illegal.
- REQ: `mem_req=1`. Address, be, we and wdata stay stable until `mem_ack` is sampled high. Then go to RESP.
- RESP: `done=1` for one cycle, then back to IDLE.
- Store byte enables: SB gives `4'b0001<<addr[1:0]`, SH gives `4'b0011<<addr[1:0]`, SW gives `4'b1111`.
- Store write data: SB `{4{sd[7:0]}}`, SH `{2{sd[15:0]}}`, SW `sd`.
- Loads use `mem_be=4'b1111` and `mem_we=0`. Let `s = mem_rdata >> (8*addr[1:0])`:
  - LB: sign-extend `s[7:0]`; LBU: zero-extend `s[7:0]`.
  - LH: sign-extend `s[15:0]`; LHU: zero-extend `s[15:0]`.
  - LW: `mem_rdata`.
- `load_data` is registered on the ack cycle. It is not updated on stores or faults.
- `start` while busy is ignored. `mem_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE. `busy`, `done`, `fault`, `mem_req`, `mem_we` are 0. `mem_addr`, `mem_be`, `mem_wdata`, `load_data` are 0.
- All outputs are registered.
- Start accepted at cycle N: `mem_req` rises at N+1.
- Ack sampled at cycle M ≥ N+1: `done` at M+1, `load_data` valid from M+1, `mem_req` low from M+1.
- Minimum latency `start` to `done` is 2 cycles.
- Fault path: `done` and `fault` at N+1, with `mem_req` never asserted.
- Back-to-back: a new `start` is accepted in the cycle after `done`.
- Reset asserted mid-REQ: `mem_req` drops asynchronously and the transaction is abandoned with no `done`.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - Once it reaches `TIMEOUT` without ack, the FSM drops `mem_req` and goes to RESP with `done=1` and `fault=1`. `load_data` is unchanged.
- `LSU_TIMEOUT_EN` undefined: REQ waits indefinitely for `mem_ack`, and no counter logic exists.

## Test plan
- LB at `addr=0x103`, `mem_rdata=0x80FF1234`, ack in the first REQ cycle:
  - `mem_addr=0x100`, `mem_be=4'b1111`, `done` 2 cycles after `start`.
  - `load_data=0xFFFFFF80`.
  - LBU of the same gives `0x00000080`.
- SH at `addr=0x22`, `store_data=0xDEADBEEF`, ack delayed 3 cycles:
  - `mem_we=1`, `mem_be=4'b1100`, `mem_wdata=0xBEEFBEEF`, held stable for 4 REQ cycles.
  - `done` 1 cycle after ack.
- LW at `addr=0x41`: `done=fault=1` at N+1, `mem_req` stays 0, `load_data` unchanged. Repeat with load funct3 `3'b011`: same result.
- R-type opcode with `start=1`: no `busy`, `done`, or `mem_req`. `start` pulsed during a pending REQ: ignored, and exactly one `done` results.
- `rst` asserted while REQ is waiting: `mem_req=0` immediately and no `done`. After release, a new SW at `0x10` completes normally with `mem_be=4'b1111`.
- With `LSU_TIMEOUT_EN`, `TIMEOUT=16`, ack never asserted: `mem_req` high for 16 cycles, then `done=fault=1`. Without the macro, `mem_req` remains high for 100 cycles.
